turn_signal_sched: RTL

//  Scheduler for the tail-light sequencing FSM. Arbitrates the left and right request switches,

---
 rtl/turn_sched_pkg.sv | 24 ++
 rtl/switch_debounce.sv | 59 +++++
 rtl/turn_signal_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/turn_sched_pkg.sv
// Shared types and constants for the turn-signal scheduler.
// Holds the mode encoding, the synchronizer depth and the mode-selection rule.
package turn_sched_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } sched_state_t;

  // Mode chosen from the filtered requests. Both requests always win as HAZARD.
  function automatic sched_state_t pick_mode(input logic req_l, input logic req_r);
    sched_state_t m;
    if (req_l && req_r) m = HAZARD;
    else if (req_l)     m = LEFT;
    else if (req_r)     m = RIGHT;
    else                m = IDLE;
    return m;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer for one raw switch, followed by an optional stability filter.
// The filter is present only when DEBOUNCE_SW_EN is defined; otherwise req_o is the synchronizer output.
module switch_debounce
`ifdef DEBOUNCE_SW_EN
#(
  parameter int DB_CYCLES = 3
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic req_o
);
  import turn_sched_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_SW_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // The counter only runs while the synchronized level disagrees with the accepted level;
  // any agreement restarts it, so a change must persist DB_CYCLES cycles to be accepted.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) filt_d = synced;
      else                             cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign req_o = filt_q;
`else
  assign req_o = synced;
`endif

endmodule

// File: rtl/turn_signal_sched.sv
// Tail-light sequence scheduler: grants LEFT/RIGHT/HAZARD and paces it with a step strobe.
// Optional switch filter enabled by defining DEBOUNCE_SW_EN.
module turn_signal_sched #(
  parameter int TICK_DIV  = 4,
  parameter int SEQ_LEN   = 4,
  parameter int DB_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       switch_left,
  input  logic                       switch_right,
  output logic                       step_en,
  output logic [$clog2(SEQ_LEN)-1:0] step_idx,
  output logic                       sel_left,
  output logic                       sel_right,
  output logic                       sel_hazard,
  output logic                       busy
);
  import turn_sched_pkg::*;

  localparam int DIVW = $clog2(TICK_DIV);
  localparam int IDXW = $clog2(SEQ_LEN);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(TICK_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SEQ_LEN - 1);

  if (TICK_DIV < 2 || SEQ_LEN < 2 || DB_CYCLES < 1) begin : g_bad_params
    $error("turn_signal_sched: TICK_DIV and SEQ_LEN must be >= 2, DB_CYCLES >= 1");
  end

  logic req_l, req_r;

  switch_debounce
`ifdef DEBOUNCE_SW_EN
    #(.DB_CYCLES(DB_CYCLES))
`endif
    u_db_left (
      .clk   (clk),
      .reset (reset),
      .sw_i  (switch_left),
      .req_o (req_l)
    );

  switch_debounce
`ifdef DEBOUNCE_SW_EN
    #(.DB_CYCLES(DB_CYCLES))
`endif
    u_db_right (
      .clk   (clk),
      .reset (reset),
      .sw_i  (switch_right),
      .req_o (req_r)
    );

  sched_state_t    state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            step_en_q, step_en_d;
  logic            sel_left_q, sel_right_q, sel_hazard_q, busy_q;

  // Modes are re-evaluated only from IDLE or at the final step of a sequence, so a
  // granted sequence can never be cut short by a request change.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    idx_d   = idx_q;
    if (state_q == IDLE) begin
      idx_d   = '0;
      state_d = pick_mode(req_l, req_r);
    end else if (div_q == DIV_LAST) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        state_d = pick_mode(req_l, req_r);
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
    step_en_d = (state_d != IDLE) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      idx_q        <= '0;
      step_en_q    <= 1'b0;
      sel_left_q   <= 1'b0;
      sel_right_q  <= 1'b0;
      sel_hazard_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      step_en_q    <= step_en_d;
      sel_left_q   <= (state_d == LEFT);
      sel_right_q  <= (state_d == RIGHT);
      sel_hazard_q <= (state_d == HAZARD);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign step_en    = step_en_q;
  assign step_idx   = idx_q;
  assign sel_left   = sel_left_q;
  assign sel_right  = sel_right_q;
  assign sel_hazard = sel_hazard_q;
  assign busy       = busy_q;

endmodule
